// File: rtl/data_mem_ctrl.sv
// Data memory for the MEM stage: valid/ready request, one-cycle response, byte lanes, wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module data_mem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [32:0] LP_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic        r_rsp_ld;
  logic [1:0]  r_rsp_size;
  logic        r_rsp_uns;
  logic [1:0]  r_rsp_sh;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdword;

  logic        w_accept;
  logic        w_commit;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_off;
  logic        w_err;
  logic [1:0]  w_lo;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_lane;
  logic [3:0]  w_wr_en;
  logic [31:0] w_wrep;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  assign req_ready = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_accept  = req_valid && req_ready;

  // With no wait states the access commits on the accept edge, so it must use the live request.
  assign w_we    = (WAIT_CYCLES == 0) ? req_we       : r_we;
  assign w_size  = (WAIT_CYCLES == 0) ? req_size     : r_size;
  assign w_uns   = (WAIT_CYCLES == 0) ? req_unsigned : r_uns;
  assign w_addr  = (WAIT_CYCLES == 0) ? req_addr     : r_addr;
  assign w_wdata = (WAIT_CYCLES == 0) ? req_wdata    : r_wdata;

  assign w_commit = !rst && ((WAIT_CYCLES == 0) ? w_accept
                                                : (r_state == ST_WAIT && r_cnt == 4'd1));

  assign w_off = w_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_lo  = w_addr[1:0];
  assign w_err = ({1'b0, w_off} >= LP_BYTES) || (w_size == 2'b11) ||
                 (w_size == 2'b01 && w_addr[0]) || (w_size == 2'b10 && w_addr[1:0] != 2'b00);
`else
  assign w_lo  = (w_size == 2'b10) ? 2'b00 :
                 (w_size == 2'b01) ? {w_addr[1], 1'b0} : w_addr[1:0];
  assign w_err = ({1'b0, w_off} >= LP_BYTES) || (w_size == 2'b11);
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = (w_size == 2'b00) ? (w_lo == 2'(gi)) :
                          (w_size == 2'b01) ? (w_lo[1] == 1'(gi / 2)) : 1'b1;
      assign w_wrep[8*gi +: 8] = (w_size == 2'b00) ? w_wdata[7:0] :
                                 (w_size == 2'b01) ? w_wdata[8*(gi%2) +: 8] :
                                                     w_wdata[8*gi +: 8];
      assign w_wr_en[gi] = w_commit && w_we && !w_err && w_lane[gi];
    end
  endgenerate

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_commit) r_rdword <= r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_ld    <= 1'b0;
      r_rsp_size  <= 2'b00;
      r_rsp_uns   <= 1'b0;
      r_rsp_sh    <= 2'b00;
    end else begin
      r_rsp_valid <= w_commit;
      if (w_commit) begin
        r_rsp_err  <= w_err;
        r_rsp_ld   <= !w_we && !w_err;
        r_rsp_size <= w_size;
        r_rsp_uns  <= w_uns;
        r_rsp_sh   <= w_lo;
      end
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      case (r_state)
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_RESP;
        end
        default: begin
          if (w_accept) begin
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            r_cnt   <= LP_WAIT;
          end else if (r_state == ST_RESP) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Formatting uses fields captured at commit so the response holds until the next one.
  assign w_shifted = r_rdword >> {r_rsp_sh, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_rsp_size)
      2'b00:   w_ext = {{24{!r_rsp_uns && w_shifted[7]}},  w_shifted[7:0]};
      2'b01:   w_ext = {{16{!r_rsp_uns && w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_ld ? w_ext : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) against a byte-addressed reference memory.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;
  localparam int MEMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  vld;
  logic        we;
  logic [1:0]  sz;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  rr, rv, re;
  logic [31:0] rd0, rd1;
  logic [31:0] got;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mb [2][MEMB];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rr[0]), .req_we(we),
    .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd0), .rsp_err(re[0]));

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rr[1]), .req_we(we),
    .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd1), .rsp_err(re[1]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic bit m_err(input logic [1:0] s, input logic [31:0] a);
    if (a >= 32'(MEMB)) return 1'b1;
    if (s == 2'b11) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (s == 2'b01 && a[0]) return 1'b1;
    if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_ea(input logic [1:0] s, input logic [31:0] a);
    int ea;
    ea = int'(a);
`ifndef DMEM_MISALIGN_TRAP_EN
    if (s == 2'b01) ea = ea - (ea % 2);
    if (s == 2'b10) ea = ea - (ea % 4);
`endif
    return ea;
  endfunction

  // Reference: memory as a flat byte array, accesses as n consecutive bytes.
  task automatic m_apply(input int k, input bit w, input logic [1:0] s, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output bit exp_err);
    int n, ea;
    exp_err = m_err(s, a);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      n  = 1 << s;
      ea = m_ea(s, a);
      for (int i = 0; i < n; i++) begin
        if (w) mb[k][ea+i] = wd[8*i +: 8];
        else   exp_rd[8*i +: 8] = mb[k][ea+i];
      end
      if (!w && !u && s == 2'b00 && exp_rd[7])  exp_rd[31:8]  = 24'hFF_FFFF;
      if (!w && !u && s == 2'b01 && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int k, input bit w, input logic [1:0] s, input bit u,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rdv);
    logic [31:0] exp_rd;
    bit exp_err;
    int c;
    we = w; sz = s; uns = u; addr = a; wdata = wd;
    check_eq("ready_before", 32'(rr[k]), 32'd1);
    vld[k] = 1'b1;
    step;
    vld[k] = 1'b0;
    m_apply(k, w, s, u, a, wd, exp_rd, exp_err);
    c = 0;
    while (!rv[k] && c < 20) begin
      check_eq("ready_busy", 32'(rr[k]), 32'd0);
      step;
      c++;
    end
    check_eq("latency", 32'(c), 32'(wait_of(k)));
    rdv = (k == 1) ? rd1 : rd0;
    check_eq("rdata", rdv, exp_rd);
    check_eq("err", 32'(re[k]), 32'(exp_err));
    $display("txn k=%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d",
             k, w, s, u, a, wd, rdv, re[k]);
    step;
    check_eq("pulse_end", 32'(rv[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_rd;
    bit exp_err;
    bit seen;
    vld = 2'b00; we = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) step;
    rst = 1'b0;
    step;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_ready", 32'(rr[k]), 32'd1);
      check_eq("rst_valid", 32'(rv[k]), 32'd0);
      check_eq("rst_err",   32'(re[k]), 32'd0);
    end
    check_eq("rst_rdata0", rd0, 32'd0);
    check_eq("rst_rdata1", rd1, 32'd0);

    for (int wi = 0; wi < DEPTH; wi++)
      for (int k = 0; k < 2; k++)
        do_txn(k, 1'b1, 2'b10, 1'b0, 32'(wi * 4), $urandom, got);

    for (int k = 0; k < 2; k++) begin
      do_txn(k, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
      do_txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
      check_eq("lw_deadbeef", got, 32'hDEADBEEF);
      do_txn(k, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, got);
      do_txn(k, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, got);
      do_txn(k, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);
      check_eq("lb_sext", got, 32'hFFFFFF80);
      do_txn(k, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got);
      check_eq("lbu_zext", got, 32'h00000080);
      do_txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
      check_eq("lw_after_sb", got, 32'h80223344);
      do_txn(k, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, got);
      do_txn(k, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, got);
      do_txn(k, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, got);
      check_eq("lh_sext", got, 32'hFFFFBEEF);
      do_txn(k, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got);
      check_eq("lw_after_sh", got, 32'hBEEF0000);
      do_txn(k, 1'b0, 2'b10, 1'b0, 32'(MEMB), 32'h0, got);
      check_eq("oor_err", 32'(re[k]), 32'd1);
      do_txn(k, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, got);
      do_txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
      check_eq("size11_nowrite", got, 32'h80223344);
      do_txn(k, 1'b1, 2'b01, 1'b0, 32'h20, 32'h00001234, got);
      do_txn(k, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
      check_eq("lh21_trap", got, 32'h0);
`else
      check_eq("lh21_align", got, 32'h00001234);
`endif
    end

    // Back-to-back store then load to the same word, no idle cycle between accepts.
    we = 1'b1; sz = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'hA5A5A5A5;
    check_eq("b2b_ready0", 32'(rr[0]), 32'd1);
    vld[0] = 1'b1;
    step;
    m_apply(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5, exp_rd, exp_err);
    check_eq("b2b_st_valid", 32'(rv[0]), 32'd1);
    check_eq("b2b_st_rdata", rd0, 32'd0);
    check_eq("b2b_ready1", 32'(rr[0]), 32'd1);
    we = 1'b0;
    step;
    vld[0] = 1'b0;
    m_apply(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, exp_rd, exp_err);
    check_eq("b2b_ld_valid", 32'(rv[0]), 32'd1);
    check_eq("b2b_ld_rdata", rd0, exp_rd);
    check_eq("b2b_ld_const", rd0, 32'hA5A5A5A5);
    $display("txn b2b k=0 store/load addr=00000040 rdata=%h", rd0);
    step;
    check_eq("b2b_end", 32'(rv[0]), 32'd0);

    // Reset in the middle of a waited store drops it entirely.
    do_txn(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111, got);
    we = 1'b1; sz = 2'b10; addr = 32'h30; wdata = 32'h22222222;
    vld[1] = 1'b1;
    step;
    vld[1] = 1'b0;
    step;
    check_eq("rstw_busy", 32'(rr[1]), 32'd0);
    rst = 1'b1;
    step;
    check_eq("rstw_ready_in_rst", 32'(rr[1]), 32'd1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rv[1]) seen = 1'b1;
      step;
    end
    check_eq("rstw_no_rsp", 32'(seen), 32'd0);
    check_eq("rstw_ready", 32'(rr[1]), 32'd1);
    $display("txn rst-during-wait k=1 addr=00000030 dropped");
    do_txn(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, got);
    check_eq("rstw_unchanged", got, 32'h11111111);

    for (int i = 0; i < 80; i++) begin
      int          k;
      bit          w;
      logic [1:0]  s;
      logic [31:0] a;
      k = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEMB + 15));
      do_txn(k, w, s, 1'($urandom_range(0, 1)), a, $urandom, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
